// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALUFun codes, FSM encoding and size limits.
package alu_arbiter_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    localparam logic [5:0] FUN_ADD = 6'b000000;
    localparam logic [5:0] FUN_SUB = 6'b000001;
    localparam logic [5:0] FUN_AND = 6'b011000;
    localparam logic [5:0] FUN_OR  = 6'b011110;
    localparam logic [5:0] FUN_SLL = 6'b100000;
    localparam logic [5:0] FUN_EQ  = 6'b110011;
    localparam logic [5:0] FUN_LT  = 6'b110101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational 32-bit ALU selected by a 6-bit ALUFun code.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  alu_fun,
    input  logic        sign,
    output logic [31:0] z
);

    always_comb begin
        z = '0;
        case (alu_fun)
            FUN_ADD: z = a + b;
            FUN_SUB: z = a - b;
            FUN_AND: z = a & b;
            FUN_OR:  z = a | b;
            // Shift amount comes from A, the shifted value from B.
            FUN_SLL: z = b << a[4:0];
            FUN_EQ:  z = {31'd0, a == b};
            FUN_LT:  z = {31'd0, sign ? ($signed(a) < $signed(b)) : (a < b)};
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb_picker.sv
// Grant picker: one-hot grant plus binary index. ALU_ARB_RR_EN selects round-robin
// starting at ptr; otherwise fixed priority, lowest index wins.
module alu_arb_picker
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_valid,
`ifdef ALU_ARB_RR_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;

    // NOTE: found is a blocking scratch variable; it must be assigned before use in
    // every pass, which also keeps this block free of inferred latches.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
`ifdef ALU_ARB_RR_EN
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i] && (i == (int'(ptr) + k) % N_REQ)) begin
                    found   = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
`endif
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = found && (gnt_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ valid/ready requesters: IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [6*N_REQ-1:0]    req_fun,
    input  logic [N_REQ-1:0]      req_sign,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_z,
    output logic                  busy
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [5:0]       op_fun_q, op_fun_d;
    logic             op_sign_q, op_sign_d;
    logic [31:0]      rsp_z_q, rsp_z_d;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic [31:0]      alu_z;
    logic             rsp_ack;
`ifdef ALU_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

    alu_arb_picker #(.N_REQ(N_REQ)) u_picker (
        .req_valid (req_valid),
`ifdef ALU_ARB_RR_EN
        .ptr       (ptr_q),
`endif
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );

    alu u_alu (
        .a       (op_a_q),
        .b       (op_b_q),
        .alu_fun (op_fun_q),
        .sign    (op_sign_q),
        .z       (alu_z)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_fun_d  = op_fun_q;
        op_sign_d = op_sign_q;
        rsp_z_d   = rsp_z_q;
`ifdef ALU_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        req_ready = '0;
        rsp_valid = '0;
        rsp_ack   = 1'b0;

        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                rsp_valid[i] = (state_q == ST_RESP);
                rsp_ack      = rsp_ready[i];
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Reset gating keeps req_ready low while reset is held with requests pending.
                req_ready = reset ? '0 : gnt;
                if (|req_valid) begin
                    state_d = ST_EXEC;
                    owner_d = gnt_idx;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt_idx == IDX_W'(i)) begin
                            op_a_d    = req_a[32*i +: 32];
                            op_b_d    = req_b[32*i +: 32];
                            op_fun_d  = req_fun[6*i +: 6];
                            op_sign_d = req_sign[i];
                        end
                    end
`ifdef ALU_ARB_RR_EN
                    ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
`endif
                end
            end
            ST_EXEC: begin
                rsp_z_d = alu_z;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register here, operands included, is cleared by reset so an
    // aborted operation leaves no stale data visible on rsp_z.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_fun_q  <= '0;
            op_sign_q <= 1'b0;
            rsp_z_q   <= '0;
`ifdef ALU_ARB_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_fun_q  <= op_fun_d;
            op_sign_q <= op_sign_d;
            rsp_z_q   <= rsp_z_d;
`ifdef ALU_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign rsp_z = rsp_z_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (N_REQ=2): directed vectors, expected responses
// queued at issue and compared by an independent monitor on each response handshake.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N = 2;

    typedef struct {
        int          port;
        logic [31:0] z;
    } exp_t;

    typedef struct {
        logic [5:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] z;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [6*N-1:0]  req_fun;
    logic [N-1:0]    req_sign;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_z;
    logic            busy;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    alu_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_fun   (req_fun),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [5:0] fun,
                            input logic [31:0] a, input logic [31:0] b, input logic s);
        req_valid[p]       = v;
        req_fun[6*p +: 6]  = fun;
        req_a[32*p +: 32]  = a;
        req_b[32*p +: 32]  = b;
        req_sign[p]        = s;
    endtask

    task automatic push_exp(input int p, input logic [31:0] z);
        exp_t e;
        e.port = p;
        e.z    = z;
        sb.push_back(e);
    endtask

    // Raise a request, hold it until accepted, then drop it right after the accept edge.
    task automatic issue(input int p, input logic [5:0] fun, input logic [31:0] a,
                         input logic [31:0] b, input logic s, input logic [31:0] z);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        set_port(p, 1'b1, fun, a, b, s);
        push_exp(p, z);
        for (int c = 0; c < 20 && !acc; c++) begin
            #1;
            if (req_ready[p]) acc = 1'b1;
            @(negedge clk);
        end
        req_valid[p] = 1'b0;
        check("issue_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && sb.size() > 0; c++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: compares on every response handshake, independent of the stimulus.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if ((rsp_valid & rsp_ready) != '0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_rsp: got rsp_valid=%b rsp_z=0x%08h, required no response",
                             rsp_valid, rsp_z);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_port", {30'd0, rsp_valid}, 32'd1 << mon_e.port);
                    check("rsp_z", rsp_z, mon_e.z);
                end
            end
        end
    end

    logic [N-1:0] exp_g[4];
    logic [31:0]  exp_cz[4];
    logic [N-1:0] got_g[4];
    int           ng;
    vec_t         vecs[5];

    initial begin
`ifdef ALU_ARB_RR_EN
        exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_cz = '{32'd7, 32'h0000_F000, 32'd7, 32'h0000_F000};
`else
        exp_g  = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_cz = '{32'd7, 32'd7, 32'd7, 32'd7};
`endif
        vecs[0] = '{FUN_EQ,  32'd5,         32'd6, 1'b0, 32'd0};
        vecs[1] = '{FUN_LT,  32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1};
        vecs[2] = '{FUN_LT,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0};
        vecs[3] = '{FUN_SLL, 32'd31,        32'd1, 1'b0, 32'h8000_0000};
        vecs[4] = '{FUN_SUB, 32'd0,         32'd1, 1'b0, 32'hFFFF_FFFF};

        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_fun   = '0;
        req_sign  = '0;
        rsp_ready = '1;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_z", rsp_z, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single op: ADD 5+7 on port 0, exact latency
        @(negedge clk);
        set_port(0, 1'b1, FUN_ADD, 32'd5, 32'd7, 1'b0);
        push_exp(0, 32'd12);
        #1;
        check("t1_req_ready", {30'd0, req_ready}, 32'b01);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t1_busy_exec", {31'd0, busy}, 32'd1);
        check("t1_no_rsp_in_exec", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("t1_rsp_valid", {30'd0, rsp_valid}, 32'b01);
        check("t1_rsp_z", rsp_z, 32'd12);
        @(negedge clk);
        #1;
        check("t1_busy_dropped", {31'd0, busy}, 32'd0);

        // Contention from reset: port 0 SUB 10-3, port 1 AND 0xF0F0 & 0xFF00
        @(negedge clk);
        reset = 1'b1;
        set_port(0, 1'b1, FUN_SUB, 32'd10, 32'd3, 1'b0);
        set_port(1, 1'b1, FUN_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
        for (int i = 0; i < 4; i++) push_exp((exp_g[i] == 2'b01) ? 0 : 1, exp_cz[i]);
        @(negedge clk);
        reset = 1'b0;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (req_ready != '0) begin
                got_g[ng] = req_ready;
                ng++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        check("cont_grant_count", ng, 4);
        for (int i = 0; i < 4; i++) check($sformatf("cont_grant%0d", i), {30'd0, got_g[i]}, {30'd0, exp_g[i]});
        drain();

        // Back-pressure: port 1 OR held in RESP for 10 cycles, port 0 EQ waiting
        @(negedge clk);
        rsp_ready = '0;
        set_port(1, 1'b1, FUN_OR, 32'h0000_00F0, 32'h0000_0A00, 1'b0);
        push_exp(1, 32'h0000_0AF0);
        #1;
        check("bp_req_ready_p1", {30'd0, req_ready}, 32'b10);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_port(0, 1'b1, FUN_EQ, 32'd9, 32'd9, 1'b0);
        push_exp(0, 32'd1);
        #1;
        check("bp_req_ready_exec", {30'd0, req_ready}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check("bp_rsp_valid_hold", {30'd0, rsp_valid}, 32'b10);
            check("bp_rsp_z_hold", rsp_z, 32'h0000_0AF0);
            check("bp_req_ready_zero", {30'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        check("bp_nonowner_ready_ignored", {30'd0, rsp_valid}, 32'b10);
        @(negedge clk);
        rsp_ready = 2'b10;
        @(negedge clk);
        #1;
        check("bp_next_accept_ready", {30'd0, req_ready}, 32'b01);
        check("bp_idle_after_release", {31'd0, busy}, 32'd0);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '1;
        #1;
        check("bp_next_accepted", {31'd0, busy}, 32'd1);
        drain();

        // Reset mid-operation: ADD dropped in EXEC, then SLL 4,1 gives 16
        @(negedge clk);
        set_port(0, 1'b1, FUN_ADD, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        #1;
        check("rst_mid_in_exec", {31'd0, busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_mid_rsp_z", rsp_z, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("rst_mid_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        issue(0, FUN_SLL, 32'd4, 32'd1, 1'b0, 32'd16);
        drain();

        // ALU patterns on port 1, including compare and shift boundaries
        for (int i = 0; i < 5; i++) issue(1, vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].z);
        drain();

        // Withdrawal: port 1 pulses req_valid for one cycle while in RESP
        rsp_ready = '0;
        issue(0, FUN_ADD, 32'd2, 32'd3, 1'b0, 32'd5);
        @(negedge clk);
        set_port(1, 1'b1, FUN_OR, 32'd1, 32'd2, 1'b0);
        #1;
        check("wd_req_ready_resp", {30'd0, req_ready}, 32'd0);
        check("wd_rsp_valid", {30'd0, rsp_valid}, 32'b01);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rsp_ready = '1;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("wd_no_accept", {31'd0, busy}, 32'd0);
            check("wd_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between `N_REQ` requesters, e.g. the integer pipeline and the branch/compare unit, through per-port valid/ready handshakes. Each request is arbitrated, its operands are registered, the ALU is evaluated for one cycle and the result is registered and returned to the winning port. It sits between the issue logic and the single ALU datapath and owns all sequencing of that ALU.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in N_REQ: per-port request valid.
- `req_ready` out N_REQ: per-port accept, one-hot or zero.
- `req_a` in 32*N_REQ: operand A, port i at bits [32i+31:32i].
- `req_b` in 32*N_REQ: operand B, same packing as `req_a`.
- `req_fun` in 6*N_REQ: ALUFun code per port.
- `req_sign` in N_REQ: Sign flag per port.
- `rsp_valid` out N_REQ: result valid, one-hot or zero.
- `rsp_ready` in N_REQ: per-port result accept.
- `rsp_z` out 32: result, meaningful only while any `rsp_valid` bit is high.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The arbiter picks `gnt` from `req_valid`; `req_ready[gnt]=1`, all other bits 0.
  - If `req_valid[gnt]`, then at the edge: latch `req_a`/`req_b`/`req_fun`/`req_sign` of `gnt` into op registers, latch `gnt` into `owner`, go to EXEC.
  - If no port is valid, stay in IDLE. `req_ready` is 0 when no port is valid.
- EXEC: the ALU is driven only from the op registers. At the edge, capture its Z into `rsp_z` and go to RESP.
- RESP:
  - `rsp_valid[owner]=1`.
  - On `rsp_ready[owner]`, go to IDLE at the edge.
  - `rsp_z` and `owner` hold until then.
  - `rsp_ready` on non-owner ports is ignored.
- Requests are not sticky. A port may drop `req_valid` before it is accepted, and it may change its operands while not yet accepted.
- ALUFun codes are passed to the ALU unchanged; the arbiter does not decode or check them.
- Reset, including mid-operation: state IDLE, `req_ready=0`, `rsp_valid=0`, `rsp_z=0`, `busy=0`, pointer 0, op registers and `owner` cleared. An in-flight operation is dropped and produces no response.

## Timing
- Accept at edge T, then EXEC in cycle T+1.
- `rsp_valid` and `rsp_z` are registered outputs, visible from T+2; response latency is 2 cycles.
- Minimum issue interval is 3 cycles: the next accept is possible in the first IDLE cycle after the response handshake.
- Response back-pressure stalls in RESP indefinitely. No requests are accepted meanwhile (`req_ready=0`).
- `req_ready` is combinational from `req_valid`, state and pointer. It does not depend on `rsp_ready`.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - Pointer `ptr`; the search starts at `ptr` and wraps modulo N_REQ.
  - On accept, `ptr <= (gnt+1) mod N_REQ`, wrapping N_REQ-1 to 0.
  - A lone active requester wins every slot.
- `ALU_ARB_RR_EN` not defined: fixed priority, lowest index wins, and the pointer register is not built.

## Structure
- Shared package/header holds:
  - ALUFun code constants: ADD 000000, SUB 000001, AND 011000, OR 011110, SLL 100000, EQ 110011, LT 110101.
  - FSM state encodings.
  - The `MAX_REQ=8` limit.
- One sub-module, `alu_arb_picker`, computes the one-hot `gnt` plus the binary index from `req_valid` and `ptr`, with fixed or round-robin selection per the macro.
- The `alu` is instantiated once inside `alu_arbiter`.

## Test plan
- Single op: port 0 ADD A=5, B=7.
  - `req_ready[0]` is high the same cycle.
  - `rsp_valid[0]` rises 2 edges after accept with `rsp_z=12`.
  - With `rsp_ready` held high, `busy` drops the following cycle.
- Contention, RR enabled: ports 0 and 1 hold SUB 10-3 and AND 0xF0F0&0xFF00 from reset.
  - Grants go 0, 1, 0, 1.
  - Results are 7 and 0xF000, each on the correct `rsp_valid` bit.
- Contention, RR disabled: same stimulus; port 0 wins every slot and port 1 is never granted while port 0 stays valid.
- Back-pressure: hold `rsp_ready=0` for 10 cycles after a result.
  - `rsp_z` stays stable and `req_ready` stays 0 on all ports.
  - Release: response completes, then the next request is accepted in the following IDLE cycle.
- Reset mid-operation: assert `reset` during EXEC.
  - All outputs are 0 immediately (asynchronously).
  - No response appears afterwards.
  - The next request after deassertion returns a correct result (SLL A=4, B=1 gives 16).
- Request withdrawal: port 1 pulses `req_valid` for one cycle while the arbiter is in RESP. No accept occurs, and no spurious response is produced later.
